ahb_sram_slave: RTL

- AHB responder that terminates one HSEL line of the AHB interconnect and fronts an internal word-organised SRAM.
- Accepts pipelined address/data-phase transfers from the interconnect and returns HREADYOUT/HRESP/HRDATA into the interconnect's S<n>_* response inputs.
- Supports a programmable number of wait states, byte/halfword/word writes, and a two-cycle ERROR response for illegal accesses.
- Never issues RETRY or SPLIT.

---
 rtl/ahb_pkg.sv | 62 ++++++
 rtl/ahb_sram_slave_mem.sv | 31 +++
 rtl/ahb_sram_slave.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// AHB protocol codes, FSM encoding and address-phase helpers
// shared by the SRAM responder and its memory array.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic [2:0]  size;
  } aphase_t;

  function automatic logic [3:0] byte_en(
    input logic [2:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      size == HSIZE_BYTE: be = 4'b0001 << off;
      size == HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:            be = 4'b1111;
    endcase
    return be;
  endfunction

  // Oversized, misaligned, or beyond the array inside the window.
  function automatic logic addr_err(
    input logic [2:0]  size,
    input logic [15:0] addr,
    input int          aw
  );
    logic bad_size;
    logic mis;
    logic oob;
    bad_size = size > HSIZE_WORD;
    mis = (size == HSIZE_HALF && addr[0]) ||
          (size == HSIZE_WORD && addr[1:0] != 2'b00);
    oob = (addr >> (aw + 2)) != 16'h0000;
    return bad_size | mis | oob;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Word-organised SRAM: DEPTH x 32, byte write enables.
// Ports: clk, we/be/waddr/wdata write port, raddr/rdata async read.
module ahb_sram_slave_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB responder in front of a word SRAM with wait states and ERROR.
// Ports: HCLK/HRST, AHB address+data phase in, HREADYOUT/HRESP/HRDATA out.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [15:0] HSPLIT,
  output logic [31:0] HRDATA
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state;
  logic [3:0]  wcnt;
  aphase_t     ap_q;
  logic        pend_q;
  logic        hready_q;
  logic [1:0]  hresp_q;

  logic        sample;
  logic        err;
  logic        done;
  logic        we;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        unused;

  assign sample = HSEL & HREADY & HTRANS[1];
  assign err    = addr_err(HSIZE, HADDR[15:0], ADDR_W);

  // IDLE with a legal phase pending is the completing cycle.
  assign done = pend_q && (state == ST_IDLE);

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      state    <= ST_IDLE;
      wcnt     <= 4'd0;
      ap_q     <= '0;
      pend_q   <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else begin
      unique case (state)
        ST_IDLE, ST_ERR2: begin
          state    <= ST_IDLE;
          pend_q   <= 1'b0;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          if (sample) begin
            ap_q.addr  <= HADDR[15:0];
            ap_q.write <= HWRITE;
            ap_q.size  <= HSIZE;
            if (err) begin
              state    <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= HRESP_ERROR;
            end else if (WAIT_STATES == 0) begin
              pend_q <= 1'b1;
            end else begin
              state    <= ST_WAIT;
              wcnt     <= WS;
              pend_q   <= 1'b1;
              hready_q <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A reset edge must not commit a write still in its data phase.
  assign we = done & ap_q.write & ~HRST;
  assign be = byte_en(ap_q.size, ap_q.addr[1:0]);

  ahb_sram_slave_mem #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (HCLK),
    .we   (we),
    .be   (be),
    .waddr(ap_q.addr[ADDR_W+1:2]),
    .wdata(HWDATA),
    .raddr(ap_q.addr[ADDR_W+1:2]),
    .rdata(rdata)
  );

  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  assign HSPLIT    = 16'h0000;
  assign HRDATA    = (done && !ap_q.write) ? rdata : 32'h0;

  assign unused = ^{HBURST, HPROT, HADDR[31:16], ap_q};

endmodule
